// File: rtl/audio_nios_led_pkg.sv
// -----------------------------------------------------------------------------
// audio_nios_led_pkg
// Shared constants and helpers for the LED PWM / blink block that sits between
// the Nios LED PIO and the board LED pins.
//   - Avalon word addresses of the configuration/status registers
//   - reset values and the PWM counter width
//   - gamma_map(): perceptual brightness curve used when the block is built
//     with AUDIO_NIOS_LED_PWM_GAMMA_EN defined
// -----------------------------------------------------------------------------
package audio_nios_led_pkg;

  // PWM counter width; one PWM period is 2**PWM_W ticks.
  localparam int PWM_W = 8;

  // Brightness register reset value: fully on.
  localparam logic [7:0] BRIGHT_RST = 8'hFF;

  // Duty value that means "always on" rather than "on while pwm_cnt < duty".
  localparam logic [7:0] DUTY_FULL = 8'hFF;

  // Avalon word addresses.
  typedef enum logic [1:0] {
    REG_BRIGHT     = 2'd0,
    REG_BLINK_PER  = 2'd1,
    REG_BLINK_MASK = 2'd2,
    REG_STATUS     = 2'd3
  } reg_addr_e;

  // Squared-brightness curve: (b*b + 255) >> 8 in a 16-bit intermediate.
  // The +255 rounds upward so that any non-trivial brightness stays visible
  // and 255 maps back to exactly 255 (b*b + 255 = 65280 fits in 16 bits).
  function automatic logic [7:0] gamma_map(input logic [7:0] b);
    logic [15:0] sq;
    sq = (16'(b) * 16'(b)) + 16'd255;
    return sq[15:8];
  endfunction

endpackage

// File: rtl/audio_nios_led_pwm_timebase.sv
// -----------------------------------------------------------------------------
// audio_nios_led_pwm_timebase
// Prescaler and PWM counter for the LED block.
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   o_tick     out  one-cycle pulse every PRESCALE_DIV clocks (prescaler wrap)
//   o_frame    out  one-cycle pulse when pwm_cnt wraps 255 -> 0 on a tick
//   o_pwm_cnt  out  PWM position, advances once per tick
// -----------------------------------------------------------------------------
module audio_nios_led_pwm_timebase
  import audio_nios_led_pkg::*;
#(
  parameter int PRESCALE_DIV = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             o_tick,
  output logic             o_frame,
  output logic [PWM_W-1:0] o_pwm_cnt
);

  // A divider below 1 makes no sense; treat it as "tick every clock".
  localparam int DIV = (PRESCALE_DIV < 1) ? 1 : PRESCALE_DIV;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]    r_presc;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic             w_tick;

  assign w_tick = (r_presc == PW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Natural 8-bit wrap gives 255 -> 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  assign o_tick    = w_tick;
  assign o_frame   = w_tick & (r_pwm_cnt == '1);
  assign o_pwm_cnt = r_pwm_cnt;

endmodule

// File: rtl/audio_nios_led_pwm.sv
// -----------------------------------------------------------------------------
// audio_nios_led_pwm
// Brightness PWM and per-LED blinking applied to the LED PIO pattern before it
// reaches the board pins, with a small Avalon-MM slave for configuration.
//
// Ports:
//   clk          in   system clock (single domain)
//   reset_n      in   asynchronous active-low reset
//   address      in   Avalon word address (0 bright, 1 blink period,
//                     2 blink mask, 3 status)
//   chipselect   in   Avalon select
//   write_n      in   active-low write strobe
//   writedata    in   write data
//   readdata     out  combinational readback, zero-extended
//   led_pattern  in   pattern from the LED PIO out_port
//   led_out      out  registered LED drive, 2 clk after led_pattern
//
// Build option: define AUDIO_NIOS_LED_PWM_GAMMA_EN to pass brightness through
// a squared curve when it is loaded into the active duty. Register readback is
// the raw written value in both builds.
// -----------------------------------------------------------------------------
module audio_nios_led_pwm
  import audio_nios_led_pkg::*;
#(
  parameter int LED_W        = 26,
  parameter int PRESCALE_DIV = 16,
  parameter int BLINK_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [LED_W-1:0]  led_pattern,
  output logic [LED_W-1:0]  led_out
);

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  logic               w_wr;
  logic               w_wr_bright;
  logic               w_wr_per;
  logic               w_wr_mask;

  logic [7:0]         r_bright;
  logic [BLINK_W-1:0] r_blink_per;
  logic [LED_W-1:0]   r_blink_mask;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_bright = w_wr & (address == REG_BRIGHT);
  assign w_wr_per    = w_wr & (address == REG_BLINK_PER);
  assign w_wr_mask   = w_wr & (address == REG_BLINK_MASK);

  // Writes to the status address fall through without effect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bright     <= BRIGHT_RST;
      r_blink_per  <= '0;
      r_blink_mask <= '0;
    end else begin
      if (w_wr_bright) r_bright     <= writedata[7:0];
      if (w_wr_per)    r_blink_per  <= writedata[BLINK_W-1:0];
      if (w_wr_mask)   r_blink_mask <= writedata[LED_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Timebase
  // ---------------------------------------------------------------------------
  logic             w_tick;
  logic             w_frame;
  logic             w_frame_load;
  logic [PWM_W-1:0] w_pwm_cnt;

  audio_nios_led_pwm_timebase #(
    .PRESCALE_DIV (PRESCALE_DIV)
  ) u_timebase (
    .clk       (clk),
    .reset_n   (reset_n),
    .o_tick    (w_tick),
    .o_frame   (w_frame),
    .o_pwm_cnt (w_pwm_cnt)
  );

  // The frame pulse is only ever asserted on a tick; the AND keeps the
  // frame-update condition self-describing where it is consumed.
  assign w_frame_load = w_tick & w_frame;

  // ---------------------------------------------------------------------------
  // Active duty: reloaded only at the PWM period boundary so a brightness
  // change cannot cut a period short. A write landing in the frame cycle
  // itself is forwarded so it governs the period that is about to start.
  // ---------------------------------------------------------------------------
  logic [7:0] r_active_duty;
  logic [7:0] w_duty_src;
  logic [7:0] w_duty_load;

  assign w_duty_src = w_wr_bright ? writedata[7:0] : r_bright;

`ifdef AUDIO_NIOS_LED_PWM_GAMMA_EN
  assign w_duty_load = gamma_map(w_duty_src);
`else
  assign w_duty_load = w_duty_src;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active_duty <= DUTY_FULL;
    end else if (w_frame_load) begin
      r_active_duty <= w_duty_load;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink phase: counts frames, toggles every blink_period frames.
  // ---------------------------------------------------------------------------
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic [BLINK_W-1:0] w_blink_cnt_next;
  logic               w_blink_phase_next;

  always_comb begin
    w_blink_cnt_next   = r_blink_cnt;
    w_blink_phase_next = r_blink_phase;
    // A period rewrite restarts the blink sequence and wins over a frame that
    // happens in the same cycle; period 0 parks blinking in the "on" phase.
    if (w_wr_per || (r_blink_per == '0)) begin
      w_blink_cnt_next   = '0;
      w_blink_phase_next = 1'b0;
    end else if (w_frame_load) begin
      if (r_blink_cnt == (r_blink_per - 1'b1)) begin
        w_blink_cnt_next   = '0;
        w_blink_phase_next = ~r_blink_phase;
      end else begin
        w_blink_cnt_next   = r_blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_blink_cnt   <= w_blink_cnt_next;
      r_blink_phase <= w_blink_phase_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output path: pattern register, per-LED gating, output register.
  // ---------------------------------------------------------------------------
  logic [LED_W-1:0] r_pat_q;
  logic [LED_W-1:0] r_led_out;
  logic [LED_W-1:0] w_on;
  logic             w_pwm_on;

  // Duty 255 must be solid on, which the plain "<" compare cannot express.
  assign w_pwm_on = (r_active_duty == DUTY_FULL) | (w_pwm_cnt < r_active_duty);

  genvar gi;
  generate
    for (gi = 0; gi < LED_W; gi++) begin : g_led
      assign w_on[gi] = r_pat_q[gi] & w_pwm_on & ~(r_blink_mask[gi] & r_blink_phase);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat_q   <= '0;
      r_led_out <= '0;
    end else begin
      r_pat_q   <= led_pattern;
      r_led_out <= w_on;
    end
  end

  assign led_out = r_led_out;

  // ---------------------------------------------------------------------------
  // Readback
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (reg_addr_e'(address))
      REG_BRIGHT:     readdata[7:0]         = r_bright;
      REG_BLINK_PER:  readdata[BLINK_W-1:0] = r_blink_per;
      REG_BLINK_MASK: readdata[LED_W-1:0]   = r_blink_mask;
      REG_STATUS:     readdata[PWM_W:0]     = {r_blink_phase, w_pwm_cnt};
      default:        readdata              = '0;
    endcase
  end

  // Upper writedata bits beyond the widest register are don't-care.
  logic w_unused;
  assign w_unused = ^writedata;

endmodule

// File: tb/tb_audio_nios_led_pwm.sv
module tb_audio_nios_led_pwm;

  localparam int LED_W   = 26;
  localparam int DIV     = 2;
  localparam int BLINK_W = 16;
  localparam int FRAME   = DIV * 256;

`ifdef AUDIO_NIOS_LED_PWM_GAMMA_EN
  localparam int EXP_HI_40 = 32;   // (64*64+255)>>8 = 16 ticks
  localparam int EXP_HI_80 = 128;  // (128*128+255)>>8 = 64 ticks
`else
  localparam int EXP_HI_40 = 128;  // 64 ticks
  localparam int EXP_HI_80 = 256;  // 128 ticks
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = 2'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = 32'd0;
  logic [31:0]      readdata;
  logic [LED_W-1:0] led_pattern = '0;
  logic [LED_W-1:0] led_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit done = 1'b0;

  audio_nios_led_pwm #(
    .LED_W        (LED_W),
    .PRESCALE_DIV (DIV),
    .BLINK_W      (BLINK_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .led_pattern (led_pattern),
    .led_out     (led_out)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model. The timebase is derived arithmetically from m_k, the
  // number of clock edges since reset release: pwm position = (k / DIV) % 256,
  // and a frame boundary is the last edge of every FRAME-edge block.
  // ---------------------------------------------------------------------------
  int               m_k;
  logic [7:0]       m_bright;
  logic [15:0]      m_per;
  logic [LED_W-1:0] m_mask;
  logic [7:0]       m_duty;
  int               m_cnt;
  logic             m_phase;
  logic [LED_W-1:0] m_pat;
  logic [LED_W-1:0] m_led;

  int         t_pwm;
  bit         t_frame;
  bit         t_on;
  bit         t_wr;
  logic [7:0] t_b;

  function automatic logic [7:0] duty_of(input logic [7:0] b);
`ifdef AUDIO_NIOS_LED_PWM_GAMMA_EN
    int sq;
    sq = int'(b) * int'(b) + 255;
    return 8'(sq / 256);
`else
    return b;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_k <= 0; m_bright <= 8'hFF; m_per <= '0; m_mask <= '0;
      m_duty <= 8'hFF; m_cnt <= 0; m_phase <= 1'b0; m_pat <= '0; m_led <= '0;
    end else begin
      t_wr    = chipselect && !write_n;
      t_pwm   = (m_k / DIV) % 256;
      t_frame = (m_k % FRAME) == FRAME - 1;
      t_on    = (m_duty == 8'd255) || (t_pwm < int'(m_duty));
      m_led  <= t_on ? (m_pat & ~(m_phase ? m_mask : '0)) : '0;
      if (t_frame) begin
        t_b = (t_wr && address == 2'd0) ? writedata[7:0] : m_bright;
        m_duty <= duty_of(t_b);
      end
      if (t_wr && address == 2'd1) begin
        m_cnt <= 0; m_phase <= 1'b0;
      end else if (m_per == 16'd0) begin
        m_cnt <= 0; m_phase <= 1'b0;
      end else if (t_frame) begin
        if (m_cnt + 1 == int'(m_per)) begin
          m_cnt <= 0; m_phase <= ~m_phase;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
      if (t_wr) begin
        case (address)
          2'd0: m_bright <= writedata[7:0];
          2'd1: m_per    <= writedata[15:0];
          2'd2: m_mask   <= writedata[LED_W-1:0];
          default: ;
        endcase
      end
      m_pat <= led_pattern;
      m_k   <= m_k + 1;
    end
  end

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[7:0]       = m_bright;
      2'd1: r[15:0]      = m_per;
      2'd2: r[LED_W-1:0] = m_mask;
      default: r[8:0]    = {m_phase, 8'((m_k / DIV) % 256)};
    endcase
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      check("model_led_out", 32'(led_out), 32'(m_led));
      check("model_readdata", readdata, exp_read(address));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change only at negedges, literal checks at +2)
  // ---------------------------------------------------------------------------
  task automatic wait_pos(input int target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < FRAME + 8 && !hit; i++) begin
      @(negedge clk);
      if (m_k % FRAME == target) hit = 1'b1;
    end
    if (!hit) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_pos: got position %0d required %0d", m_k % FRAME, target);
    end
  endtask

  // Must be called exactly at a negedge; the write lands on the next posedge.
  task automatic wr_now(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    #2 check(nm, readdata, exp);
  endtask

  // High cycles of led_out[0] over one whole PWM period.
  task automatic count_high(output int cnt);
    wait_pos(1);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i != 0) @(negedge clk);
      if (led_out[0]) cnt++;
    end
  endtask

  logic [LED_W-1:0] blink_exp [4] = '{26'h3, 26'h3, 26'h2, 26'h2};

  initial begin
    int hi;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #2 check("rst_led_out", 32'(led_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state readback (status first, before pwm_cnt can advance).
    rd_chk("rst_status", 2'd3, 32'd0);
    rd_chk("rst_bright", 2'd0, 32'h0000_00FF);
    rd_chk("rst_blink_per", 2'd1, 32'd0);
    rd_chk("rst_blink_mask", 2'd2, 32'd0);

    // Pattern latency: two clocks.
    @(negedge clk);
    led_pattern = '1;
    @(negedge clk);
    #2 check("latency_1clk", 32'(led_out), 32'd0);
    @(negedge clk);
    #2 check("latency_2clk", 32'(led_out), 32'h03FF_FFFF);

    // Mid-frame brightness change waits for the frame boundary.
    wait_pos(100);
    wr_now(2'd0, 32'h40);
    #2 check("old_duty_held_a", 32'(led_out[0]), 32'd1);
    wait_pos(400);
    #2 check("old_duty_held_b", 32'(led_out[0]), 32'd1);
    count_high(hi);
    check("duty_0x40_high", hi, EXP_HI_40);
    rd_chk("bright_0x40", 2'd0, 32'h40);

    wait_pos(100);
    wr_now(2'd0, 32'h0);
    count_high(hi);
    check("duty_0_high", hi, 0);

    // Write exactly in the frame cycle: new value governs the new period.
    wait_pos(FRAME - 1);
    wr_now(2'd0, 32'h80);
    count_high(hi);
    check("boundary_0x80_high", hi, EXP_HI_80);
    rd_chk("bright_0x80", 2'd0, 32'h80);

    // Blink: period 2 on bit 0 only.
    wait_pos(100);
    wr_now(2'd0, 32'hFF);
    wait_pos(1);
    wr_now(2'd1, 32'd2);
    wr_now(2'd2, 32'h1);
    led_pattern = 26'h3;
    for (int j = 0; j < 4; j++) begin
      wait_pos(256);
      #2 check($sformatf("blink_frame%0d", j), 32'(led_out), 32'(blink_exp[j]));
    end
    address = 2'd3;
    #1 check("status_phase1", 32'(readdata[8]), 32'd1);
    @(negedge clk);
    wr_now(2'd1, 32'd2);
    @(negedge clk);
    #2 check("period_rewrite_clears", 32'(led_out), 32'h3);

    // Reset asserted while blink phase is 1.
    wait_pos(256);
    #2 check("phase0_after_rewrite", 32'(led_out), 32'h3);
    wait_pos(256);
    #2 check("phase1_before_rst", 32'(led_out), 32'h2);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check("async_rst_led", 32'(led_out), 32'd0);
    address = 2'd3;
    #1 check("async_rst_status", readdata, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd_chk("post_rst_bright", 2'd0, 32'h0000_00FF);
    rd_chk("post_rst_blink_per", 2'd1, 32'd0);
    rd_chk("post_rst_blink_mask", 2'd2, 32'd0);
    for (int j = 0; j < 2; j++) begin
      wait_pos(256);
      #2 check($sformatf("no_blink_frame%0d", j), 32'(led_out), 32'h3);
    end

    @(negedge clk);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL watchdog: got timeout required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

endmodule

// File: doc/audio_nios_led_pwm.md
Name: audio_nios_led_pwm

Overview:
- Downstream consumer of the 26-bit LED PIO output port; sits between the PIO and the board LED pins.
- Applies global PWM brightness and per-LED blinking to the software-written LED pattern.
- Has its own small Avalon-MM slave (2-bit word address) for configuration and status, driven by the Nios data master.

Parameters:
- LED_W, 26, width of pattern and LED outputs.
- PRESCALE_DIV, 16, clk cycles per PWM tick (minimum 1).
- BLINK_W, 16, width of the blink period register.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational from address, zero-extended.
- led_pattern  in  LED_W  pattern from the LED PIO out_port.
- led_out  out  LED_W  registered drive to the LED pins.

Behaviour:
- Registers (write = chipselect & ~write_n):
  - addr0: brightness[7:0], reset 8'hFF.
  - addr1: blink_period[BLINK_W-1:0], reset 0.
  - addr2: blink_mask[LED_W-1:0], reset 0.
  - addr3: read-only status {23'b0, blink_phase, pwm_cnt[7:0]}; writes to addr3 are ignored.
- Readback: returns stored register values immediately after a write; unused upper bits read 0.
- Timebase:
  - Prescaler counts 0..PRESCALE_DIV-1 and asserts tick when it wraps.
  - pwm_cnt (8b) increments on each tick and wraps 255->0.
  - frame = cycle in which pwm_cnt wraps 255->0 on a tick.
- Duty:
  - active_duty loads on frame only, so a brightness change never glitches mid-period.
  - If brightness is written in the frame cycle, the written value (bypass) is loaded.
  - Reset value of active_duty: 8'hFF.
- Blink:
  - blink_cnt increments on frame. When blink_cnt == blink_period-1, blink_cnt clears and blink_phase toggles.
  - blink_period == 0 holds blink_phase = 0 and blink_cnt = 0.
  - Writing blink_period clears blink_cnt and blink_phase in the same cycle; this takes priority over the frame increment.
- Output:
  - led_pattern is registered once (pat_q).
  - on_i = pat_q[i] & pwm_on & ~(blink_mask[i] & blink_phase).
  - pwm_on = (active_duty == 8'hFF) ? 1 : (pwm_cnt < active_duty). Duty 0 is always off; duty 255 is always on.
  - led_out is registered from on_i. Latency from led_pattern to led_out is 2 clk.
- Reset (asserted at any time, including mid-frame):
  - all counters 0, blink_phase 0, pat_q 0, led_out 0.
  - registers return to their reset values; status reads 0.
- No handshakes or backpressure; Avalon writes complete in one cycle.

Optional Feature:
- Macro: AUDIO_NIOS_LED_PWM_GAMMA_EN.
- Defined: at frame load, active_duty = (b*b + 255) >> 8, with b = brightness, using a 16-bit intermediate. This gives b=0→0, 16→1, 128→64, 255→255.
- Undefined: active_duty = b.
- Register readback is identical in both builds.

Decomposition:
- Package audio_nios_led_pkg contains:
  - register address constants (REG_BRIGHT=0, REG_BLINK_PER=1, REG_BLINK_MASK=2, REG_STATUS=3).
  - reset constants (BRIGHT_RST=8'hFF).
  - PWM counter width (8).
- Sub-module audio_nios_led_pwm_timebase:
  - contains the prescaler and pwm_cnt.
  - outputs tick, frame and pwm_cnt.
  - instantiated once in the top.

Test Plan (PRESCALE_DIV=2, so 1 frame = 512 clk):
- Reset state: reset, then release -> led_out=0; reads return addr0=0xFF, addr1=0, addr2=0, addr3=0. Set pattern=26'h3FFFFFF -> led_out all 1 at clk+2, steady.
- Duty: write brightness=0x40 mid-frame -> old duty persists until frame. In the following frame, led_out[0] high for exactly 128 clk of 512. brightness=0 -> constant 0.
- Write on boundary: write brightness=0x80 in exactly the frame cycle -> 0x80 governs that frame (256 high clk), not the previous value.
- Blink: blink_period=2, mask=26'h1, pattern=26'h3 -> bit0 toggles every 2 frames (1024 clk) and bit1 unaffected. Rewriting period clears the phase immediately.
- Reset mid-operation: assert reset_n low during blink_phase=1 -> led_out=0 asynchronously. After release, brightness reads 0xFF and blinking is off.
- Gamma build: with AUDIO_NIOS_LED_PWM_GAMMA_EN defined, brightness=0x80 -> 64 high PWM ticks per frame (128 clk). Without the macro -> 128 ticks (256 clk).
